// File: rtl/voice_alloc_pkg.sv
// Shared types and defaults for the voice allocator: FSM state encoding,
// default field widths and the scan-candidate record.
package voice_alloc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } alloc_state_t;

    localparam int DEF_KEY_W = 7;
    localparam int DEF_VEL_W = 7;
    localparam int DEF_SEQ_W = 16;

    // Candidate fields are sized for the largest supported pool (64 voices)
    // and the widest supported stamp (32 bits); narrower values zero-extend.
    localparam int CAND_IDX_W = 6;
    localparam int CAND_AGE_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CAND_IDX_W-1:0] idx;
        logic [CAND_AGE_W-1:0] age;
    } cand_t;

    // A qualifying voice replaces the held candidate only when strictly older,
    // so with an ascending scan an equal age keeps the lower index.
    function automatic logic cand_better(input cand_t cur, input logic [CAND_AGE_W-1:0] age);
        return (!cur.valid) || (age > cur.age);
    endfunction

endpackage

// File: rtl/voice_cand_cmp.sv
// One step of a running "best voice so far" search: folds voice idx with the
// given age into the current candidate when the voice qualifies and wins.
module voice_cand_cmp
    import voice_alloc_pkg::*;
(
    input  cand_t                 cur,
    input  logic [CAND_IDX_W-1:0] idx,
    input  logic [CAND_AGE_W-1:0] age,
    input  logic                  qualifies,
    output cand_t                 nxt
);

    // Next candidate: take this voice if it qualifies and beats the holder.
    always_comb begin
        nxt = cur;
        if (qualifies && cand_better(cur, age)) begin
            nxt.valid = 1'b1;
            nxt.idx   = idx;
            nxt.age   = age;
        end else begin
            nxt = cur;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice pool scheduler: accepts note-on/off events, scans every voice once
// per event to find a retrigger/free/steal target, then issues one gate
// command and updates the held-key map.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = 32,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int VEL_W  = DEF_VEL_W,
    parameter int SEQ_W  = DEF_SEQ_W,
    localparam int VW    = $clog2(VOICES)
) (
    input  logic              fpga_clk,
    input  logic              reset,
    input  logic              evt_valid,
    output logic              evt_ready,
    input  logic              evt_on,
    input  logic [KEY_W-1:0]  evt_key,
    input  logic [VEL_W-1:0]  evt_vel,
    input  logic              all_notes_off,
    input  logic [VOICES-1:0] voice_free,
    output logic [VOICES-1:0] keys_on,
    output logic              gate_valid,
    output logic              gate_on,
    output logic              gate_steal,
    output logic [VW-1:0]     gate_voice,
    output logic [KEY_W-1:0]  gate_key,
    output logic [VEL_W-1:0]  gate_vel
);

    alloc_state_t      state_r, state_nxt_s;
    logic [VW-1:0]     scan_idx_r;
    logic [VOICES-1:0] keys_on_r;
    logic [KEY_W-1:0]  key_r   [VOICES];
    logic [SEQ_W-1:0]  stamp_r [VOICES];
    logic [SEQ_W-1:0]  seq_r;
    logic              all_off_pend_r;

    logic              ev_on_r;
    logic [KEY_W-1:0]  ev_key_r;
    logic [VEL_W-1:0]  ev_vel_r;

    cand_t match_r, free_r, rel_r, held_r;
    cand_t match_nxt_s, free_nxt_s, rel_nxt_s, held_nxt_s;

    logic                  evt_ready_s, accept_s, scanning_s, last_scan_s, all_off_apply_s;
    logic [SEQ_W-1:0]      age_raw_s;
    logic [CAND_AGE_W-1:0] age_s;
    logic [CAND_IDX_W-1:0] cidx_s;
    logic                  held_here_s, match_here_s, free_here_s;
    logic                  dec_fire_s, dec_on_s, dec_steal_s;
    logic [VW-1:0]         dec_voice_s;

    assign evt_ready_s     = (state_r == IDLE) && !all_off_pend_r && !all_notes_off && !reset;
    assign evt_ready       = evt_ready_s;
    assign accept_s        = evt_valid && evt_ready_s;
    assign scanning_s      = (state_r == SCAN);
    assign last_scan_s     = scanning_s && (scan_idx_r == VW'(VOICES - 1));
    assign all_off_apply_s = (state_r == IDLE) && all_off_pend_r;
    assign keys_on         = keys_on_r;

    // Per-voice facts for the voice currently under the scan pointer.
    assign age_raw_s    = seq_r - stamp_r[scan_idx_r];
    assign age_s        = CAND_AGE_W'(age_raw_s);
    assign cidx_s       = CAND_IDX_W'(scan_idx_r);
    assign held_here_s  = keys_on_r[scan_idx_r];
    assign match_here_s = held_here_s && (key_r[scan_idx_r] == ev_key_r);
    assign free_here_s  = voice_free[scan_idx_r] && !held_here_s;

    // Free search ignores age so the first (lowest) free voice sticks.
    voice_cand_cmp u_free_cmp (
        .cur       (free_r),
        .idx       (cidx_s),
        .age       ({CAND_AGE_W{1'b0}}),
        .qualifies (free_here_s),
        .nxt       (free_nxt_s)
    );

    voice_cand_cmp u_rel_cmp (
        .cur       (rel_r),
        .idx       (cidx_s),
        .age       (age_s),
        .qualifies (!held_here_s),
        .nxt       (rel_nxt_s)
    );

    voice_cand_cmp u_held_cmp (
        .cur       (held_r),
        .idx       (cidx_s),
        .age       (age_s),
        .qualifies (1'b1),
        .nxt       (held_nxt_s)
    );

    // Key-match candidate: the first held voice carrying the event key.
    always_comb begin
        match_nxt_s = match_r;
        if (match_here_s && !match_r.valid) begin
            match_nxt_s.valid = 1'b1;
            match_nxt_s.idx   = cidx_s;
            match_nxt_s.age   = {CAND_AGE_W{1'b0}};
        end else begin
            match_nxt_s = match_r;
        end
    end

    // Allocation decision from the final candidates, used on the last scan cycle.
    always_comb begin
        dec_fire_s  = 1'b0;
        dec_on_s    = 1'b0;
        dec_steal_s = 1'b0;
        dec_voice_s = {VW{1'b0}};
        if (ev_on_r) begin
            dec_fire_s = 1'b1;
            dec_on_s   = 1'b1;
            if (match_nxt_s.valid) begin
                dec_voice_s = VW'(match_nxt_s.idx);
            end else if (free_nxt_s.valid) begin
                dec_voice_s = VW'(free_nxt_s.idx);
            end else if (rel_nxt_s.valid) begin
                dec_voice_s = VW'(rel_nxt_s.idx);
                dec_steal_s = 1'b1;
            end else begin
                dec_voice_s = VW'(held_nxt_s.idx);
                dec_steal_s = 1'b1;
            end
        end else begin
            if (match_nxt_s.valid) begin
                dec_fire_s  = 1'b1;
                dec_voice_s = VW'(match_nxt_s.idx);
            end else begin
                dec_fire_s  = 1'b0;
            end
        end
    end

    // FSM next state: one scan pass per accepted event, then a DONE beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? SCAN : IDLE;
            SCAN:    state_nxt_s = last_scan_s ? DONE : SCAN;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scan pointer and candidate registers, cleared at each accept.
    always_ff @(posedge fpga_clk) begin
        if (reset || accept_s) begin
            scan_idx_r <= {VW{1'b0}};
            match_r    <= {1'b0, {CAND_IDX_W{1'b0}}, {CAND_AGE_W{1'b0}}};
            free_r     <= {1'b0, {CAND_IDX_W{1'b0}}, {CAND_AGE_W{1'b0}}};
            rel_r      <= {1'b0, {CAND_IDX_W{1'b0}}, {CAND_AGE_W{1'b0}}};
            held_r     <= {1'b0, {CAND_IDX_W{1'b0}}, {CAND_AGE_W{1'b0}}};
        end else if (scanning_s) begin
            scan_idx_r <= scan_idx_r + VW'(1'b1);
            match_r    <= match_nxt_s;
            free_r     <= free_nxt_s;
            rel_r      <= rel_nxt_s;
            held_r     <= held_nxt_s;
        end else begin
            scan_idx_r <= scan_idx_r;
        end
    end

    // Event latch; a velocity-0 note-on is folded into a note-off here.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            ev_on_r  <= 1'b0;
            ev_key_r <= {KEY_W{1'b0}};
            ev_vel_r <= {VEL_W{1'b0}};
        end else if (accept_s) begin
            ev_on_r  <= evt_on && (evt_vel != {VEL_W{1'b0}});
            ev_key_r <= evt_key;
            ev_vel_r <= evt_vel;
        end else begin
            ev_on_r  <= ev_on_r;
        end
    end

    // Voice map: held keys, per-voice key/stamp, sequence counter, all-off.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            keys_on_r      <= {VOICES{1'b0}};
            seq_r          <= {SEQ_W{1'b0}};
            all_off_pend_r <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                key_r[i]   <= {KEY_W{1'b0}};
                stamp_r[i] <= {SEQ_W{1'b0}};
            end
        end else begin
            if (last_scan_s && dec_fire_s) begin
                keys_on_r[dec_voice_s] <= dec_on_s;
                if (dec_on_s) begin
                    key_r[dec_voice_s]   <= ev_key_r;
                    stamp_r[dec_voice_s] <= seq_r;
                    seq_r                <= seq_r + SEQ_W'(1'b1);
                end
            end else if (all_off_apply_s) begin
                keys_on_r <= {VOICES{1'b0}};
            end
            if (all_notes_off) begin
                all_off_pend_r <= 1'b1;
            end else if (all_off_apply_s) begin
                all_off_pend_r <= 1'b0;
            end
        end
    end

    // Gate command: one-cycle strobe, fields held between strobes.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            gate_valid <= 1'b0;
            gate_on    <= 1'b0;
            gate_steal <= 1'b0;
            gate_voice <= {VW{1'b0}};
            gate_key   <= {KEY_W{1'b0}};
            gate_vel   <= {VEL_W{1'b0}};
        end else begin
            gate_valid <= last_scan_s && dec_fire_s;
            if (last_scan_s && dec_fire_s) begin
                gate_on    <= dec_on_s;
                gate_steal <= dec_steal_s;
                gate_voice <= dec_voice_s;
                gate_key   <= ev_key_r;
                gate_vel   <= ev_vel_r;
            end
        end
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules the shared voice pool of the synthesizer.
- Accepts decoded MIDI note-on/note-off events and selects a voice for each: retrigger of the same key, else a free voice, else steal.
- Drives keys_on, and emits one gate command per event to the per-voice oscillator/envelope datapath.
- Sits between the MIDI decoder and the voice array; voice_free comes back from the envelope generators.

Parameters:
- VOICES, 32, number of voices in the pool (2..64).
- KEY_W, 7, MIDI key number width.
- VEL_W, 7, MIDI velocity width.
- SEQ_W, 16, allocation sequence-stamp width (modulo age arithmetic).

Ports:
- fpga_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- evt_valid  in  1  event offered.
- evt_ready  out  1  allocator can accept an event.
- evt_on  in  1  1 = note-on, 0 = note-off.
- evt_key  in  KEY_W  key number.
- evt_vel  in  VEL_W  velocity.
- all_notes_off  in  1  one-cycle pulse: release every held voice.
- voice_free  in  VOICES  per voice, 1 = envelope finished and voice silent.
- keys_on  out  VOICES  per voice, 1 = key held on that voice.
- gate_valid  out  1  one-cycle gate command strobe.
- gate_on  out  1  1 = start/retrigger, 0 = release.
- gate_steal  out  1  gate_on command took a non-free voice.
- gate_voice  out  $clog2(VOICES)  target voice index.
- gate_key  out  KEY_W  key for target voice.
- gate_vel  out  VEL_W  velocity for target voice.

Behaviour:
- Clock and reset: one clock, fpga_clk. Reset is synchronous and active-high.
- Reset values:
  - keys_on = 0; all gate_* outputs = 0.
  - State = IDLE; seq = 0; all per-voice key and stamp registers = 0; all_off_pend = 0.
  - evt_ready = 0 while reset is high, 1 in the first cycle after.
- FSM: IDLE -> SCAN -> DONE -> IDLE.
- Handshake:
  - evt_ready = (state==IDLE) && !all_off_pend && !all_notes_off.
  - Accept on evt_valid && evt_ready at cycle T. The event fields are latched at T.
  - A note-on with evt_vel==0 is treated as a note-off.
- SCAN:
  - Runs cycles T+1 .. T+VOICES, visiting index i = 0..VOICES-1, one per cycle.
  - voice_free[i] is sampled in its own scan cycle.
  - Candidates tracked during the scan:
    - match: keys_on[i] && key[i]==evt_key.
    - free: voice_free[i] && !keys_on[i].
    - oldest released: !keys_on[i], largest age.
    - oldest held: largest age.
  - age = seq - stamp[i], modulo 2^SEQ_W. Ties keep the lowest index.
- DONE at cycle T+VOICES+1. gate_valid pulses for exactly one cycle, and keys_on and per-voice registers update in the same cycle.
  - Note-on priority, first match wins:
    1. match voice: retrigger, gate_steal=0.
    2. lowest free voice: gate_steal=0.
    3. oldest released voice: gate_steal=1.
    4. oldest held voice: gate_steal=1.
  - Note-on effects on the chosen voice v: keys_on[v]=1, key[v]=evt_key, stamp[v]=seq, seq=seq+1 (wraps), gate_on=1.
  - Note-off with a match: keys_on[v]=0, gate_on=0, gate_vel=evt_vel (0 for a vel-0 note-on).
  - Note-off with no match: no gate_valid, state returns to IDLE silently.
- Return to IDLE at T+VOICES+2; evt_ready reasserts there if no all-off is pending.
  - Accept-to-gate latency is fixed at VOICES+1 cycles.
  - Throughput is one event per VOICES+2 cycles.
- all_notes_off:
  - Any cycle sets all_off_pend.
  - Applied in the next IDLE cycle: keys_on = 0, no gate strobes, pend cleared, evt_ready stays 0 that cycle.
  - If it arrives during SCAN/DONE, the DONE result is applied first, then the all-off.
- gate_* fields hold their values between strobes; they are only meaningful when gate_valid=1.
- Reset mid-scan: the event is discarded, no gate_valid is issued, and all state returns to reset values.

Decomposition:
- voice_alloc_pkg holds:
  - alloc_state_t enum {IDLE, SCAN, DONE}.
  - Default KEY_W, VEL_W, SEQ_W constants.
  - The cand_t struct {valid, idx, age}.
- Sub-module voice_cand_cmp: combinational per-cycle update of one candidate register given (i, age, qualifies). It is instantiated three times, for the free, oldest-released and oldest-held candidates.

Test Plan (VOICES=4 for speed, SEQ_W=16):
- Reset, all voice_free=1, note-on key 60 vel 100 -> gate_valid exactly 5 cycles after accept, voice 0, gate_on=1, steal=0, keys_on=4'b0001; evt_ready high 6 cycles after accept.
- Note-on 60, then note-on 60 vel 80 -> second gate targets voice 0 again (retrigger), steal=0, keys_on unchanged; note-off 60 -> gate_on=0 voice 0, keys_on=0; note-off 61 -> no gate_valid.
- Note-on keys 60,61,62,63 (voice_free all 1) fill voices 0..3. Then note-on 64 -> steal voice 0, gate_steal=1. Next note-on 65 -> steal voice 1.
- Voices 0..3 full. Note-off 62, voice_free held 0 everywhere. Note-on 70 -> voice 2 is chosen (released beats held), gate_steal=1.
- Note-on with vel 0 on held key 61 -> behaves as note-off: gate_on=0, gate_vel=0.
- all_notes_off pulse during SCAN of a note-on 50 -> gate for 50 issued; the following IDLE cycle clears keys_on to 0 with evt_ready=0 for that cycle. Then force seq near 2^16-1 and verify the steal order stays correct across the wrap.
